int_seq: RTL and testbench
==========================

Name: int_seq

Overview:
- Interrupt and reset sequencer sitting directly upstream of the instruction decoder.
- Samples the NMI, IRQ and RDY pins and watches the decoder's SYNC.
- On an opcode-fetch cycle with a pending interrupt, substitutes opcode $00 (BRK) on the bus feeding the decoder, so IRQ, NMI, reset and BRK share one 7-cycle stack/vector sequence.
- Supplies the decoder/datapath with the interrupt type, vector address, B-flag value, PC-increment inhibit and write suppression.

Parameters:
- VEC_NMI, 16'hFFFA, NMI vector low-byte address.
- VEC_RST, 16'hFFFC, reset vector low-byte address.
- VEC_IRQ, 16'hFFFE, IRQ/BRK vector low-byte address.
- SEQ_LEN, 7, cycles in the interrupt sequence; counter runs 0..SEQ_LEN-1.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_din  in  8  data bus from memory (opcode on SYNC cycles)
- i_sync  in  1  SYNC from decoder (opcode fetch cycle)
- i_ready  in  1  RDY; low stalls the sequencer
- i_nmi_n  in  1  NMI pin, falling-edge sensitive
- i_irq_n  in  1  IRQ pin, level sensitive, active low
- i_iflag  in  1  processor I flag (1 = IRQ masked)
- o_din  out  8  opcode/data to decoder din
- o_int_type  out  3  int_type_e of the active sequence
- o_busy  out  1  sequence in progress
- o_seq_cnt  out  3  sequence cycle index
- o_vec  out  16  vector address for cycles 5/6 (+0 at cycle 5, +1 at cycle 6)
- o_bflag  out  1  B bit for status push
- o_inh_pc  out  1  inhibit PC increment on substituted fetch
- o_wr_sup  out  1  convert stack writes to reads (reset)

Behaviour:
- Reset (asynchronous, any time, including mid-sequence):
  - Clears nmi_pend, the edge-sample register (forced 1) and the counter.
  - Enters RST_WAIT.
  - Output reset values: o_busy=0, o_int_type=INT_RST, o_seq_cnt=0, o_vec=VEC_RST, o_bflag=0, o_inh_pc=0, o_wr_sup=1, o_din=i_din.
- States: RST_WAIT, IDLE, SEQ.
- RST_WAIT:
  - On the first i_sync after reset release, force o_din=8'h00 and o_inh_pc=1.
  - Go to SEQ with type INT_RST.
- NMI edge detection:
  - nmi_q <= i_nmi_n every cycle, independent of i_ready.
  - nmi_pend sets when nmi_q=1 and i_nmi_n=0.
  - nmi_pend clears only when an NMI sequence is accepted.
  - Set and clear in the same cycle → set wins.
- IRQ:
  - irq_req = !i_irq_n && !i_iflag, registered each cycle.
  - Not latched: if IRQ is deasserted before the decision cycle, no interrupt is taken.
- Decision (IDLE, i_sync=1, i_ready=1), priority NMI > IRQ > BRK:
  - nmi_pend → o_din=8'h00, o_inh_pc=1, type INT_NMI, clear nmi_pend.
  - Else irq_req → same substitution, type INT_IRQ.
  - Else if i_din==8'h00 → type INT_BRK, no substitution, o_inh_pc=0.
  - Enter SEQ on the following edge; o_seq_cnt=0.
  - Otherwise stay in IDLE with o_din=i_din.
- SEQ:
  - Counter advances 1 per cycle while i_ready=1 and holds while i_ready=0.
  - At SEQ_LEN-1 with i_ready=1, return to IDLE.
  - i_sync during SEQ is ignored.
  - o_busy=1 in SEQ.
  - o_bflag=1 only for INT_BRK.
  - o_wr_sup=1 only for INT_RST.
  - o_vec = VEC_NMI / VEC_RST / VEC_IRQ by type (BRK uses VEC_IRQ).
  - An NMI edge during SEQ sets nmi_pend, which is serviced at the next decision.
- Back-to-back: a decision can be taken on the SYNC immediately after SEQ ends, so NMI follows with no gap.
- Width rules: o_seq_cnt is $clog2(SEQ_LEN) bits (3); no wrap beyond SEQ_LEN-1.

Optional Feature:
- Macro: INT_SEQ_HIJACK_EN.
- Defined:
  - If nmi_pend is set while in SEQ with type INT_IRQ or INT_BRK and o_seq_cnt<=4, type switches to INT_NMI.
  - nmi_pend clears and o_vec becomes VEC_NMI.
  - o_bflag keeps its BRK value, so a hijacked BRK pushes B=1.
- Undefined: no hijack; the NMI stays pending until the next decision.

Decomposition:
- Package int_pkg:
  - enum int_type_e {INT_NONE, INT_BRK, INT_IRQ, INT_NMI, INT_RST}, 3 bits.
  - Default vector constants.
  - OP_BRK=8'h00.
- Sub-module nmi_edge_det: sample flop plus pending latch, with set-dominant clear input.

Test Plan:
- Release reset, i_sync=1 with i_din=8'hA9 → o_din=8'h00, o_inh_pc=1. SEQ runs with o_wr_sup=1 and o_vec=16'hFFFC at cnt 5, then returns to IDLE after 7 cycles.
- i_nmi_n 1→0 two cycles before SYNC, i_din=8'hEA → o_din=8'h00, type INT_NMI, o_vec=16'hFFFA, o_bflag=0. A second SYNC without a new edge → no interrupt.
- i_irq_n=0 with i_iflag=1 → opcode passes through. With i_iflag=0 → INT_IRQ, o_vec=16'hFFFE. IRQ released before SYNC → no interrupt.
- i_din=8'h00 at SYNC → INT_BRK, o_bflag=1, o_inh_pc=0. With i_ready low for 3 cycles at cnt 2, o_seq_cnt holds at 2 and the sequence ends 3 cycles late.
- With INT_SEQ_HIJACK_EN, NMI edge at IRQ cnt 3 → type INT_NMI, o_vec=16'hFFFA. Without the macro, the NMI is taken at the next SYNC.
- Assert i_rst at NMI cnt 4 → outputs immediately take their reset values, nmi_pend=0, and the next SYNC runs the reset sequence.

Source files
------------

// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt/reset sequencer.
// Holds the interrupt type encoding, default vectors and the BRK opcode.
package int_pkg;

    typedef enum logic [2:0] {
        INT_NONE = 3'd0,
        INT_BRK  = 3'd1,
        INT_IRQ  = 3'd2,
        INT_NMI  = 3'd3,
        INT_RST  = 3'd4
    } int_type_e;

    localparam logic [15:0] VEC_NMI_DEF = 16'hFFFA;
    localparam logic [15:0] VEC_RST_DEF = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ_DEF = 16'hFFFE;
    localparam logic [7:0]  OP_BRK      = 8'h00;

    // BRK and an idle/none type both resolve to the IRQ vector.
    function automatic logic [15:0] vec_sel(input int_type_e t,
                                            input logic [15:0] v_nmi,
                                            input logic [15:0] v_rst,
                                            input logic [15:0] v_irq);
        logic [15:0] v;
        v = v_irq;
        if (t == INT_NMI) v = v_nmi;
        if (t == INT_RST) v = v_rst;
        return v;
    endfunction

endpackage

// File: rtl/nmi_edge_det.sv
// NMI falling-edge detector: sample flop plus pending latch, one-cycle latency.
// No backpressure; a set in the same cycle as clr keeps the latch set.
module nmi_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic nmi_n,
    input  logic clr,
    output logic pend
);

    logic nmi_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nmi_q <= 1'b1;
            pend  <= 1'b0;
        end else begin
            nmi_q <= nmi_n;
            pend  <= (nmi_q & ~nmi_n) | (pend & ~clr);
        end
    end

endmodule

// File: rtl/int_seq.sv
// Interrupt/reset sequencer ahead of the decoder; opcode substitution is combinational, sequence is SEQ_LEN cycles.
// i_ready low freezes the counter; INT_SEQ_HIJACK_EN lets a fresh NMI take over an early IRQ/BRK sequence.
module int_seq
    import int_pkg::*;
#(
    parameter logic [15:0] VEC_NMI = VEC_NMI_DEF,
    parameter logic [15:0] VEC_RST = VEC_RST_DEF,
    parameter logic [15:0] VEC_IRQ = VEC_IRQ_DEF,
    parameter int          SEQ_LEN = 7
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_din,
    input  logic        i_sync,
    input  logic        i_ready,
    input  logic        i_nmi_n,
    input  logic        i_irq_n,
    input  logic        i_iflag,
    output logic [7:0]  o_din,
    output logic [2:0]  o_int_type,
    output logic        o_busy,
    output logic [2:0]  o_seq_cnt,
    output logic [15:0] o_vec,
    output logic        o_bflag,
    output logic        o_inh_pc,
    output logic        o_wr_sup
);

    localparam int              CW       = $clog2(SEQ_LEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(SEQ_LEN - 1);
    localparam logic [1:0]      ST_RST_WAIT = 2'd0;
    localparam logic [1:0]      ST_IDLE     = 2'd1;
    localparam logic [1:0]      ST_SEQ      = 2'd2;

    logic [1:0]    state;
    int_type_e     typ;
    logic [CW-1:0] cnt;
    logic          bflag;
    logic          irq_req;
    logic          nmi_pend;
    logic          nmi_clr;
    logic          decide;
    logic          take_rst;
    logic          take_nmi;
    logic          take_irq;
    logic          take_brk;
    logic          subst;
    logic          hijack;

    nmi_edge_det u_nmi (
        .clk   (i_clk),
        .rst   (i_rst),
        .nmi_n (i_nmi_n),
        .clr   (nmi_clr),
        .pend  (nmi_pend)
    );

    always_comb begin
        decide   = (state == ST_IDLE) && i_sync && i_ready;
        take_rst = (state == ST_RST_WAIT) && i_sync;
        take_nmi = decide && nmi_pend;
        take_irq = decide && !nmi_pend && irq_req;
        take_brk = decide && !nmi_pend && !irq_req && (i_din == OP_BRK);
        subst    = take_rst || take_nmi || take_irq;
`ifdef INT_SEQ_HIJACK_EN
        hijack   = (state == ST_SEQ) && nmi_pend && (cnt <= CW'(4)) &&
                   ((typ == INT_IRQ) || (typ == INT_BRK));
`else
        hijack   = 1'b0;
`endif
        nmi_clr  = take_nmi || hijack;
    end

    assign o_din      = subst ? OP_BRK : i_din;
    assign o_inh_pc   = subst;
    assign o_busy     = (state == ST_SEQ);
    assign o_int_type = typ;
    assign o_seq_cnt  = 3'(cnt);
    assign o_vec      = vec_sel(typ, VEC_NMI, VEC_RST, VEC_IRQ);
    assign o_bflag    = bflag;
    assign o_wr_sup   = (typ == INT_RST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_RST_WAIT;
            typ     <= INT_RST;
            cnt     <= '0;
            bflag   <= 1'b0;
            irq_req <= 1'b0;
        end else begin
            irq_req <= !i_irq_n && !i_iflag;
            case (state)
                ST_RST_WAIT: begin
                    if (take_rst) begin
                        state <= ST_SEQ;
                        cnt   <= '0;
                    end
                end
                ST_IDLE: begin
                    if (take_nmi || take_irq || take_brk) begin
                        state <= ST_SEQ;
                        cnt   <= '0;
                        typ   <= take_nmi ? INT_NMI : (take_irq ? INT_IRQ : INT_BRK);
                        bflag <= take_brk;
                    end
                end
                ST_SEQ: begin
                    // bflag is left alone so a hijacked BRK still pushes B=1
                    if (hijack) typ <= INT_NMI;
                    if (i_ready) begin
                        if (cnt == CNT_LAST) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                            typ   <= INT_NONE;
                            bflag <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_seq.sv
// Directed bench for int_seq: decisions push expected sequence attributes, a monitor pops them at cycle 5.
module tb_int_seq;
    import int_pkg::*;

    localparam int SEQ = 7;

    typedef struct packed {
        logic [2:0]  typ;
        logic [15:0] vec;
        logic        bflag;
        logic        wr_sup;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [7:0]  din;
    logic        sync;
    logic        ready;
    logic        nmi_n;
    logic        irq_n;
    logic        iflag;
    logic [7:0]  o_din;
    logic [2:0]  o_int_type;
    logic        o_busy;
    logic [2:0]  o_seq_cnt;
    logic [15:0] o_vec;
    logic        o_bflag;
    logic        o_inh_pc;
    logic        o_wr_sup;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    exp_t mon_e;

    int_seq dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_din      (din),
        .i_sync     (sync),
        .i_ready    (ready),
        .i_nmi_n    (nmi_n),
        .i_irq_n    (irq_n),
        .i_iflag    (iflag),
        .o_din      (o_din),
        .o_int_type (o_int_type),
        .o_busy     (o_busy),
        .o_seq_cnt  (o_seq_cnt),
        .o_vec      (o_vec),
        .o_bflag    (o_bflag),
        .o_inh_pc   (o_inh_pc),
        .o_wr_sup   (o_wr_sup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] t, input logic bf);
        exp_t e;
        e.typ    = t;
        e.vec    = (t == 3'(INT_NMI)) ? 16'hFFFA : ((t == 3'(INT_RST)) ? 16'hFFFC : 16'hFFFE);
        e.bflag  = bf;
        e.wr_sup = (t == 3'(INT_RST));
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy",  32'(o_busy),     32'd0);
        chk("rst_type",  32'(o_int_type), 32'(INT_RST));
        chk("rst_cnt",   32'(o_seq_cnt),  32'd0);
        chk("rst_vec",   32'(o_vec),      32'hFFFC);
        chk("rst_bflag", 32'(o_bflag),    32'd0);
        chk("rst_inh",   32'(o_inh_pc),   32'd0);
        chk("rst_wrsup", 32'(o_wr_sup),   32'd1);
        chk("rst_din",   32'(o_din),      32'(din));
    endtask

    // et == INT_NONE means the fetch must pass through untouched
    task automatic fetch(input logic [7:0] op, input logic [2:0] et, input logic bf);
        logic sub;
        sub = (et == 3'(INT_NMI)) || (et == 3'(INT_IRQ)) || (et == 3'(INT_RST));
        din  = op;
        sync = 1'b1;
        #1;
        chk("fetch_din", 32'(o_din),    sub ? 32'd0 : 32'(op));
        chk("fetch_inh", 32'(o_inh_pc), 32'(sub));
        if (et != 3'(INT_NONE)) sb.push_back(mk(et, bf));
        step();
        sync = 1'b0;
        din  = 8'hEA;
        #1;
        chk("fetch_busy", 32'(o_busy), 32'(et != 3'(INT_NONE)));
    endtask

    task automatic seq_body(input int stall_at, input int stall_len, input int nmi_at);
        for (int c = 0; c < SEQ; c++) begin
            chk("seq_busy", 32'(o_busy), 32'd1);
            chk("seq_cnt",  32'(o_seq_cnt), 32'(c));
            if (c == nmi_at) nmi_n = 1'b0;
            sync = (c == 3);
            din  = (c == 3) ? 8'h00 : 8'hEA;
            if (c == stall_at) begin
                ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    step();
                    chk("stall_cnt", 32'(o_seq_cnt), 32'(c));
                end
                ready = 1'b1;
            end
            step();
            sync = 1'b0;
            din  = 8'hEA;
        end
        #1;
        chk("seq_done", 32'(o_busy), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && o_busy && ready && o_seq_cnt == 3'd5) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_bad++;
                $error("FAIL sb_underflow observed=%0h expected=%0h", o_int_type, 3'(INT_NONE));
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("sb_type",  32'(o_int_type), 32'(mon_e.typ));
                chk("sb_vec",   32'(o_vec),      32'(mon_e.vec));
                chk("sb_bflag", 32'(o_bflag),    32'(mon_e.bflag));
                chk("sb_wrsup", 32'(o_wr_sup),   32'(mon_e.wr_sup));
            end
        end
    end

    initial begin
        rst = 1'b1; din = 8'hA9; sync = 1'b0; ready = 1'b1;
        nmi_n = 1'b1; irq_n = 1'b1; iflag = 1'b1;
        #2;
        chk_reset_vals();
        step(); step();
        rst = 1'b0;
        step();

        // reset sequence on first SYNC
        fetch(8'hA9, 3'(INT_RST), 1'b0);
        seq_body(-1, 0, -1);

        // NMI edge two cycles before SYNC, then no repeat without a new edge
        nmi_n = 1'b0;
        step(); step();
        fetch(8'hEA, 3'(INT_NMI), 1'b0);
        seq_body(-1, 0, -1);
        nmi_n = 1'b1;
        step();
        fetch(8'hEA, 3'(INT_NONE), 1'b0);

        // IRQ masked, unmasked, and released before SYNC
        irq_n = 1'b0; iflag = 1'b1;
        step(); step();
        fetch(8'h58, 3'(INT_NONE), 1'b0);
        iflag = 1'b0;
        step();
        fetch(8'h58, 3'(INT_IRQ), 1'b0);
        irq_n = 1'b1;
        seq_body(-1, 0, -1);
        irq_n = 1'b0;
        step();
        irq_n = 1'b1;
        step();
        fetch(8'hEA, 3'(INT_NONE), 1'b0);

        // BRK with a 3-cycle RDY stall at count 2
        fetch(8'h00, 3'(INT_BRK), 1'b1);
        seq_body(2, 3, -1);

        // NMI edge during an IRQ sequence at count 3
        irq_n = 1'b0;
        step();
        fetch(8'hEA, 3'(INT_IRQ), 1'b0);
        irq_n = 1'b1;
`ifdef INT_SEQ_HIJACK_EN
        sb[sb.size() - 1] = mk(3'(INT_NMI), 1'b0);
`endif
        seq_body(-1, 0, 3);
        nmi_n = 1'b1;
`ifdef INT_SEQ_HIJACK_EN
        fetch(8'hEA, 3'(INT_NONE), 1'b0);
`else
        fetch(8'hEA, 3'(INT_NMI), 1'b0);
        seq_body(-1, 0, -1);
`endif

        // reset in the middle of an NMI sequence
        nmi_n = 1'b0;
        step(); step();
        fetch(8'hEA, 3'(INT_NMI), 1'b0);
        step(); step(); step(); step();
        chk("abort_cnt", 32'(o_seq_cnt), 32'd4);
        rst   = 1'b1;
        nmi_n = 1'b1;
        din   = 8'h4C;
        #1;
        chk_reset_vals();
        sb.delete();
        step(); step();
        rst = 1'b0;
        step();
        fetch(8'hA9, 3'(INT_RST), 1'b0);
        seq_body(-1, 0, -1);
        fetch(8'hEA, 3'(INT_NONE), 1'b0);

        step();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
